// File: rtl/uart_pkg.sv
// Shared UART definitions: default line settings, frame geometry and the RX state encoding.
package uart_pkg;

  localparam int CLK_FREQ_DEF = 50_000_000;
  localparam int BAUD_DEF     = 9600;
  localparam int DATA_BITS    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Clocks per bit for a given system clock and line rate.
  function automatic int bps_cnt(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_control_if.sv
// RX controller signal bundle: detector/line/enable in, byte and strobes out.
interface uart_rx_control_if;
  import uart_pkg::*;

  logic                 H2L_Sig;
  logic                 RX_Pin_In;
  logic                 RX_En_Sig;
  logic [DATA_BITS-1:0] RX_Data;
  logic                 RX_Done_Sig;
  logic                 Frame_Err_Sig;

  modport master (
    output H2L_Sig, RX_Pin_In, RX_En_Sig,
    input  RX_Data, RX_Done_Sig, Frame_Err_Sig
  );

  modport slave (
    input  H2L_Sig, RX_Pin_In, RX_En_Sig,
    output RX_Data, RX_Done_Sig, Frame_Err_Sig
  );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period counter shared by the UART RX and TX paths. Counts 0..BPS_CNT-1
// and flags the bit centre (mid) and the bit end (end).
module uart_baud_counter #(
  parameter int BPS_CNT = 16,
  parameter int CW      = $clog2(BPS_CNT)
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic clr,
  output logic mid_pls,
  output logic end_pls
);

  localparam logic [CW-1:0] MID_V = CW'(BPS_CNT / 2 - 1);
  localparam logic [CW-1:0] END_V = CW'(BPS_CNT - 1);

  logic [CW-1:0] cnt;

  assign mid_pls = (cnt == MID_V);
  assign end_pls = (cnt == END_V);

  // Free-running bit counter; clear forces it back to 0, end of bit wraps it.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                cnt <= '0;
    else if (clr || end_pls)  cnt <= '0;
    else                      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_rx_control.sv
// UART 8N1 receive controller. Takes the start-edge pulse from the detector,
// confirms the start bit at its centre, samples 8 data bits LSB first and the
// stop bit at bit centres, then strobes done (good byte) or framing error.
// BPS_CNT = CLK_FREQ/BAUD must be at least 4.
module uart_rx_control
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int BAUD     = BAUD_DEF
) (
  input  logic               CLK,
  input  logic               RSTn,
  uart_rx_control_if.slave   rx_if
);

  localparam int BPS_CNT = bps_cnt(CLK_FREQ, BAUD);
  localparam int BW      = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  rx_state_t            state;
  logic [1:0]           rx_sync;
  logic                 line;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 done_q;
  logic                 err_q;
  logic                 mid_pls;
  logic                 end_pls;
  logic                 cnt_clr;

  assign line                = rx_sync[1];
  assign rx_if.RX_Data       = rx_data_q;
  assign rx_if.RX_Done_Sig   = done_q;
  assign rx_if.Frame_Err_Sig = err_q;

  // Counter restarts on every state change and is held at 0 while idle, so each
  // state sees cnt==0 on its first cycle. Mirrors the transitions in the FSM.
  always_comb begin
    cnt_clr = 1'b0;
    unique case (state)
      IDLE:  cnt_clr = 1'b1;
      START: cnt_clr = mid_pls;
      DATA:  cnt_clr = end_pls && (bit_idx == LAST_BIT);
      STOP:  cnt_clr = end_pls;
      default: cnt_clr = 1'b1;
    endcase
    if (!rx_if.RX_En_Sig) cnt_clr = 1'b1;
  end

  uart_baud_counter #(.BPS_CNT(BPS_CNT)) u_baud (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .clr     (cnt_clr),
    .mid_pls (mid_pls),
    .end_pls (end_pls)
  );

  // Two-flop synchroniser on the raw line; resets to the idle (mark) level.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) rx_sync <= 2'b11;
    else       rx_sync <= {rx_sync[0], rx_if.RX_Pin_In};
  end

  // Frame FSM with registered byte and strobes. Disable aborts any frame.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state != IDLE && !rx_if.RX_En_Sig) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (rx_if.H2L_Sig && rx_if.RX_En_Sig) begin
              state   <= START;
              bit_idx <= '0;
            end
          end
          START: begin
            // A high line at the start-bit centre is a glitch, not a frame.
            if (mid_pls) state <= line ? IDLE : DATA;
          end
          DATA: begin
            if (end_pls) begin
              shreg[bit_idx] <= line;
              bit_idx        <= bit_idx + BW'(1);
              if (bit_idx == LAST_BIT) state <= STOP;
            end
          end
          STOP: begin
            // Leave at the stop-bit centre so a back-to-back start is caught.
            if (end_pls) begin
              if (line) begin
                rx_data_q <= shreg;
                done_q    <= 1'b1;
              end else begin
                err_q     <= 1'b1;
              end
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_control.sv
// Bench for uart_rx_control at BPS_CNT=16: directed and random frames, with the
// start-edge detector modelled as a pulse at each frame's start bit.
module tb_uart_rx_control;

  localparam int BPS  = 16;
  localparam int HALF = BPS / 2;
  localparam int LAT  = HALF + 9 * BPS;   // strobe registered this many edges after H2L capture
  localparam int FRM  = 10 * BPS;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  int   cyc  = 0;

  uart_rx_control_if u_if();

  uart_rx_control #(.CLK_FREQ(16), .BAUD(1)) dut (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .rx_if (u_if)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Strobe log: edge index, kind (1=done, 2=error, 3=both), byte on the bus.
  int         ev_cyc[$];
  int         ev_kind[$];
  logic [7:0] ev_dat[$];

  always @(negedge CLK) begin
    if (u_if.RX_Done_Sig || u_if.Frame_Err_Sig) begin
      ev_cyc.push_back(cyc);
      ev_kind.push_back({30'd0, u_if.Frame_Err_Sig, u_if.RX_Done_Sig});
      ev_dat.push_back(u_if.RX_Data);
    end
  end

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Drive one 8N1 frame starting at the next edge. cut>=0 stops the frame at
  // that slot with either a one-cycle disable or a one-cycle reset; xh2l>=0
  // adds a spurious detector pulse at that slot.
  task automatic send_frame(input logic [7:0] d, input logic stopb, input int cut,
                            input int xh2l, input bit do_rst, output int e0);
    logic [9:0] bits;
    bits = {stopb, d, 1'b0};
    e0 = cyc + 1;
    for (int n = 0; n < FRM; n++) begin
      u_if.RX_Pin_In = bits[n / BPS];
      u_if.H2L_Sig   = (n == 0) || (n == xh2l);
      if (n == cut) begin
        if (do_rst) begin
          RSTn = 1'b0;
          #1;
          check("rst_mid data", {24'd0, u_if.RX_Data}, 32'h00);
          check("rst_mid done", {31'd0, u_if.RX_Done_Sig}, 32'd0);
          check("rst_mid err",  {31'd0, u_if.Frame_Err_Sig}, 32'd0);
          exp_data = 8'h00;
          @(negedge CLK);
          RSTn = 1'b1;
        end else begin
          u_if.RX_En_Sig = 1'b0;
          @(negedge CLK);
          u_if.RX_En_Sig = 1'b1;
        end
        break;
      end
      @(negedge CLK);
    end
    u_if.RX_Pin_In = 1'b1;
    u_if.H2L_Sig   = 1'b0;
  endtask

  // Model of a completed frame: stop=1 delivers the byte, stop=0 is a framing
  // error with the held byte untouched; either strobe lands LAT edges after start.
  task automatic expect_frame(input string tag, input int e0, input logic [7:0] d, input logic stopb);
    int kind;
    kind = stopb ? 1 : 2;
    if (stopb) exp_data = d;
    check({tag, " count"}, ev_cyc.size(), 1);
    if (ev_cyc.size() > 0) begin
      check({tag, " time"}, ev_cyc[0] - e0, LAT);
      check({tag, " kind"}, ev_kind[0], kind);
      check({tag, " strobe_data"}, {24'd0, ev_dat[0]}, {24'd0, exp_data});
    end
    check({tag, " data"}, {24'd0, u_if.RX_Data}, {24'd0, exp_data});
    ev_cyc.delete(); ev_kind.delete(); ev_dat.delete();
  endtask

  task automatic expect_none(input string tag);
    check({tag, " count"}, ev_cyc.size(), 0);
    check({tag, " data"}, {24'd0, u_if.RX_Data}, {24'd0, exp_data});
    ev_cyc.delete(); ev_kind.delete(); ev_dat.delete();
  endtask

  initial begin
    int         e0;
    logic [7:0] rd;
    logic       rs;

    u_if.RX_Pin_In = 1'b1;
    u_if.H2L_Sig   = 1'b0;
    u_if.RX_En_Sig = 1'b1;
    exp_data       = 8'h00;
    repeat (3) @(negedge CLK);
    check("reset data", {24'd0, u_if.RX_Data}, 32'h00);
    check("reset done", {31'd0, u_if.RX_Done_Sig}, 32'd0);
    check("reset err",  {31'd0, u_if.Frame_Err_Sig}, 32'd0);
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);

    // Good frame
    send_frame(8'h55, 1'b1, -1, -1, 1'b0, e0);
    expect_frame("t1_55", e0, 8'h55, 1'b1);

    // Start-bit glitch: low for 3 clocks only
    u_if.RX_Pin_In = 1'b0; u_if.H2L_Sig = 1'b1;
    @(negedge CLK);
    u_if.H2L_Sig = 1'b0;
    repeat (2) @(negedge CLK);
    u_if.RX_Pin_In = 1'b1;
    repeat (30) @(negedge CLK);
    expect_none("t2_glitch");

    // Framing error keeps the previous byte
    send_frame(8'hA3, 1'b0, -1, -1, 1'b0, e0);
    expect_frame("t3_ferr", e0, 8'hA3, 1'b0);

    // Back-to-back frames, no idle bits
    send_frame(8'h00, 1'b1, -1, -1, 1'b0, e0);
    expect_frame("t4_00", e0, 8'h00, 1'b1);
    send_frame(8'hFF, 1'b1, -1, -1, 1'b0, e0);
    expect_frame("t4_ff", e0, 8'hFF, 1'b1);

    // Disable during data bit 3, then a frame right away
    send_frame(8'h3C, 1'b1, 4 * BPS + 7, -1, 1'b0, e0);
    expect_none("t5_dis");
    send_frame(8'h96, 1'b1, -1, -1, 1'b0, e0);
    expect_frame("t5_after_dis", e0, 8'h96, 1'b1);

    // Reset mid-frame, then a frame right away
    send_frame(8'h5A, 1'b1, 6 * BPS, -1, 1'b1, e0);
    expect_none("t5_rst");
    send_frame(8'hC7, 1'b1, -1, -1, 1'b0, e0);
    expect_frame("t5_after_rst", e0, 8'hC7, 1'b1);

    // Detector pulse while disabled, then a frame with a stray pulse in DATA
    u_if.RX_En_Sig = 1'b0; u_if.H2L_Sig = 1'b1;
    @(negedge CLK);
    u_if.RX_En_Sig = 1'b1; u_if.H2L_Sig = 1'b0;
    repeat (3) @(negedge CLK);
    send_frame(8'h81, 1'b1, -1, 5 * BPS + 5, 1'b0, e0);
    expect_frame("t6_ignore", e0, 8'h81, 1'b1);

    // Random frames, mostly good stop bits
    for (int k = 0; k < 8; k++) begin
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rd, rs, -1, -1, 1'b0, e0);
      expect_frame($sformatf("rand%0d", k), e0, rd, rs);
    end

    repeat (4) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
